// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and small sigma functions.
// Used by the message scheduler and later by the compression core.
package sha256_pkg;

   localparam int BLOCK_WORDS = 16;
   localparam int NUM_ROUNDS  = 64;

   typedef enum logic [1:0] {
      LOAD,
      EXPAND,
      DONE
   } sched_state_t;

   function automatic logic [31:0] sha256_sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sha256_sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads 16 words, then streams W0..W63
// from a 16-word sliding window over a valid/ready port.
module sha256_msg_sched #(
   parameter int NUM_ROUNDS = 64,
   parameter int WORD_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [WORD_W-1:0] m_i,
   output logic              w_valid_o,
   input  logic              w_ready_i,
   output logic [WORD_W-1:0] w_o,
   output logic [5:0]        t_o,
   output logic              block_done_o,
   output logic              busy_o,
   output logic              err_o
);

   import sha256_pkg::*;

   if (NUM_ROUNDS != 64 || WORD_W != 32) begin : g_bad_param
      $error("sha256_msg_sched: only NUM_ROUNDS=64, WORD_W=32");
   end

   localparam logic [3:0] LAST_LOAD = 4'(BLOCK_WORDS - 1);
   localparam logic [5:0] LAST_T    = 6'(NUM_ROUNDS - 1);

   sched_state_t state_q, state_d;
   logic [3:0]   load_cnt_q, load_cnt_d;
   logic [5:0]   t_q, t_d;
   logic [31:0]  win_q [16];
   logic [31:0]  win_d [16];
   logic         done_q, done_d;
   logic         err_q, err_d;
   logic [31:0]  w_next;

   // W[t+16] built from the window while W[t] is being consumed
   assign w_next = sha256_sig1(win_q[14]) + win_q[9]
                 + sha256_sig0(win_q[1]) + win_q[0];

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      t_d        = t_q;
      win_d      = win_q;
      done_d     = 1'b0;
      err_d      = err_q | (valid_i & (state_q != LOAD));
      unique case (state_q)
         LOAD: begin
            if (valid_i) begin
               win_d[load_cnt_q] = m_i;
               if (load_cnt_q == LAST_LOAD) begin
                  state_d    = EXPAND;
                  load_cnt_d = 4'd0;
                  t_d        = 6'd0;
               end else begin
                  load_cnt_d = load_cnt_q + 4'd1;
               end
            end
         end
         EXPAND: begin
            if (w_ready_i) begin
               for (int i = 0; i < 15; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[15] = w_next;
               if (t_q == LAST_T) begin
                  state_d = DONE;
                  t_d     = 6'd0;
                  done_d  = 1'b1;
               end else begin
                  t_d = t_q + 6'd1;
               end
            end
         end
         DONE: begin
            state_d    = LOAD;
            load_cnt_d = 4'd0;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD;
         load_cnt_q <= 4'd0;
         t_q        <= 6'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= 32'd0;
         end
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         t_q        <= t_d;
         done_q     <= done_d;
         err_q      <= err_d;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

   assign w_valid_o    = (state_q == EXPAND);
   assign w_o          = win_q[0];
   assign t_o          = t_q;
   assign block_done_o = done_q;
   assign busy_o       = (state_q != LOAD);
   assign err_o        = err_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched against a direct
// W[t] recurrence reference.
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [31:0] m_i;
   logic        w_valid_o;
   logic        w_ready_i;
   logic [31:0] w_o;
   logic [5:0]  t_o;
   logic        block_done_o;
   logic        busy_o;
   logic        err_o;

   sha256_msg_sched dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .m_i          (m_i),
      .w_valid_o    (w_valid_o),
      .w_ready_i    (w_ready_i),
      .w_o          (w_o),
      .t_o          (t_o),
      .block_done_o (block_done_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic void expand(input logic [31:0] m [16],
                                  output logic [31:0] w [64]);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
      end
   endfunction

   logic [37:0] sb [$];
   logic [31:0] got_w [64];
   int          cyc      = 0;
   int          done_cnt = 0;
   int          w0_cyc   = -1;
   int          done_lat = -1;
   int          rdy_mode = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      int rc;
      rc = 0;
      w_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         w_ready_i = (rdy_mode == 0) ? 1'b1 : (rc % 3 == 0);
         rc++;
      end
   end

   initial begin
      logic        stall;
      logic [31:0] st_w;
      logic [5:0]  st_t;
      logic [37:0] e;
      stall = 1'b0;
      st_w  = '0;
      st_t  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall  = 1'b0;
            w0_cyc = -1;
         end else begin
            if (stall && w_valid_o) begin
               check("stall_w", w_o, st_w);
               check("stall_t", 32'(t_o), 32'(st_t));
            end
            if (w_valid_o && t_o == 6'd0 && w0_cyc < 0) w0_cyc = cyc;
            if (block_done_o) begin
               done_cnt++;
               if (w0_cyc >= 0) done_lat = cyc - w0_cyc;
               w0_cyc = -1;
            end
            if (w_valid_o && w_ready_i) begin
               got_w[t_o] = w_o;
               if (sb.size() == 0) begin
                  check("sb_underflow", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("w", w_o, e[31:0]);
                  check("t", 32'(t_o), 32'(e[37:32]));
               end
            end
            stall = w_valid_o && !w_ready_i;
            st_w  = w_o;
            st_t  = t_o;
         end
      end
   end

   task automatic send_block(input logic [31:0] m [16], input bit gaps);
      logic [31:0] w [64];
      expand(m, w);
      for (int i = 0; i < 64; i++) sb.push_back({6'(i), w[i]});
      for (int i = 0; i < 16; i++) begin
         valid_i = 1'b1;
         m_i     = m[i];
         if (i == 15) check("vlow_before", 32'(w_valid_o), 32'd0);
         @(posedge clk);
         #1;
         valid_i = 1'b0;
         if (gaps && (i == 4 || i == 11)) begin
            repeat (3) @(posedge clk);
            #1;
         end
      end
      check("vrise", 32'(w_valid_o), 32'd1);
   endtask

   task automatic wait_done();
      int n;
      int start;
      n     = 0;
      start = done_cnt;
      while (done_cnt == start && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_seen", 32'(done_cnt - start), 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_t(input logic [5:0] tt);
      int n;
      n = 0;
      while (!(w_valid_o && t_o == tt) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_t", 32'(t_o), 32'(tt));
   endtask

   task automatic rand_block(output logic [31:0] m [16]);
      for (int i = 0; i < 16; i++) m[i] = $urandom;
   endtask

   logic [31:0] abc [16];
   logic [31:0] rb  [16];
   int          d0;

   initial begin
      for (int i = 0; i < 16; i++) abc[i] = 32'd0;
      abc[0]  = 32'h61626380;
      abc[15] = 32'h00000018;
      rst     = 1'b1;
      valid_i = 1'b0;
      m_i     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(w_valid_o), 32'd0);
      check("rst_w", w_o, 32'd0);
      check("rst_t", 32'(t_o), 32'd0);
      check("rst_done", 32'(block_done_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      send_block(abc, 1'b0);
      check("busy", 32'(busy_o), 32'd1);
      wait_done();
      check("abc_w0", got_w[0], 32'h61626380);
      check("abc_w15", got_w[15], 32'h00000018);
      check("abc_w16", got_w[16], 32'h61626380);
      check("abc_w17", got_w[17], 32'h000F0000);
      check("done_lat", 32'(done_lat), 32'd64);
      check("done_once", 32'(done_cnt), 32'd1);

      rdy_mode = 1;
      send_block(abc, 1'b0);
      wait_done();
      rdy_mode = 0;

      send_block(abc, 1'b1);
      wait_done();

      rand_block(rb);
      send_block(rb, 1'b0);
      wait_t(6'd20);
      check("err_pre", 32'(err_o), 32'd0);
      valid_i = 1'b1;
      m_i     = $urandom;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      check("err_set", 32'(err_o), 32'd1);
      wait_done();
      check("err_hold", 32'(err_o), 32'd1);
      rand_block(rb);
      send_block(rb, 1'b0);
      wait_done();
      check("err_sticky", 32'(err_o), 32'd1);

      send_block(abc, 1'b0);
      wait_t(6'd30);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mrst_valid", 32'(w_valid_o), 32'd0);
      check("mrst_err", 32'(err_o), 32'd0);
      check("mrst_t", 32'(t_o), 32'd0);
      send_block(abc, 1'b0);
      wait_done();
      check("mrst_w0", got_w[0], 32'h61626380);

      for (int i = 0; i < 7; i++) begin
         valid_i = 1'b1;
         m_i     = $urandom;
         @(posedge clk);
         #1;
      end
      valid_i = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rand_block(rb);
      send_block(rb, 1'b0);
      wait_done();

      d0 = done_cnt;
      rand_block(rb);
      send_block(rb, 1'b0);
      wait_done();
      rand_block(rb);
      send_block(rb, 1'b0);
      wait_done();
      check("two_done", 32'(done_cnt - d0), 32'd2);
      check("final_err", 32'(err_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
